prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arbiter.sv | 108 ++++++++++
 tb/tb_prio_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/prio_arbiter.sv
// Request arbiter with registered grant outputs; holds a grant until ack.
// Compile with ROUND_ROBIN_EN defined for rotating priority, otherwise fixed highest-index priority.
module prio_arbiter #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic         grant_vld,
   output logic [W-1:0] grant_idx,
   output logic [N-1:0] grant_oh,
   output logic         busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t       state_reg, state_next;
   logic         vld_reg, vld_next;
   logic [W-1:0] idx_reg, idx_next;
   logic [N-1:0] oh_reg, oh_next, sel_oh;
   logic [W-1:0] sel_idx;
   logic         issue;

   // A new grant can only be taken when nothing is held or the holder releases this cycle.
   assign issue = en && (|req) && ((state_reg == IDLE) || ack);

`ifdef ROUND_ROBIN_EN
   logic [W-1:0] ptr_reg;
   int           start;
   int           cand;
   logic [W-1:0] cand_idx;

   // Descending search from ptr-1 with wrap; the lowest offset is evaluated last so it wins.
   always_comb begin
      sel_idx  = '0;
      start    = (int'(ptr_reg) + N - 1) % N;
      cand     = 0;
      cand_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand     = (start - k + N) % N;
         cand_idx = W'(cand);
         if (req[cand_idx]) sel_idx = cand_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (issue) begin
         ptr_reg <= sel_idx;
      end
   end
`else
   always_comb begin
      sel_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (req[k]) sel_idx = W'(k);
      end
   end
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_oh
         assign sel_oh[gi] = (sel_idx == W'(gi));
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      vld_next   = vld_reg;
      idx_next   = idx_reg;
      oh_next    = oh_reg;
      case (state_reg)
         IDLE:    state_next = issue ? GRANT : IDLE;
         GRANT:   if (ack) state_next = issue ? GRANT : IDLE;
         default: state_next = IDLE;
      endcase
      if ((state_reg == IDLE) || ack) begin
         vld_next = issue;
         idx_next = issue ? sel_idx : '0;
         oh_next  = issue ? sel_oh  : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         vld_reg   <= 1'b0;
         idx_reg   <= '0;
         oh_reg    <= '0;
      end else begin
         state_reg <= state_next;
         vld_reg   <= vld_next;
         idx_reg   <= idx_next;
         oh_reg    <= oh_next;
      end
   end

   assign grant_vld = vld_reg;
   assign grant_idx = idx_reg;
   assign grant_oh  = oh_reg;
   assign busy      = (state_reg == GRANT);

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter with N=4; expectations track ROUND_ROBIN_EN when it is defined.
module tb_prio_arbiter;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [N-1:0] req;
   logic         ack;
   logic         grant_vld;
   logic [W-1:0] grant_idx;
   logic [N-1:0] grant_oh;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   prio_arbiter #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .ack       (ack),
      .grant_vld (grant_vld),
      .grant_idx (grant_idx),
      .grant_oh  (grant_oh),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks every output against one expected grant state.
   task automatic chk_all(input string tag, input logic vld, input logic [W-1:0] idx);
      logic [N-1:0] oh;
      oh = vld ? (N'(1) << idx) : '0;
      chk({tag, ".vld"},  32'(grant_vld), 32'(vld));
      chk({tag, ".idx"},  32'(grant_idx), vld ? 32'(idx) : 32'd0);
      chk({tag, ".oh"},   32'(grant_oh),  32'(oh));
      chk({tag, ".busy"}, 32'(busy),      32'(vld));
      $display("t=%0t %s en=%b req=%b ack=%b -> vld=%b idx=%0d oh=%b busy=%b",
               $time, tag, en, req, ack, grant_vld, grant_idx, grant_oh, busy);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] seq_exp [5];

   initial begin
`ifdef ROUND_ROBIN_EN
      seq_exp = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
      seq_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
      rst = 1'b1; en = 1'b0; req = '0; ack = 1'b0;
      #12;
      chk_all("reset", 1'b0, 2'd0);

      // First grant: highest pending of 0101 is channel 2 from either scheme.
      rst = 1'b0; en = 1'b1; req = 4'b0101;
      step();
      chk_all("first_grant", 1'b1, 2'd2);

      // Grant held while req and en change; channel 2 dropping its req does not revoke.
      req = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         en = (i != 1);
         step();
         chk_all($sformatf("hold%0d", i), 1'b1, 2'd2);
      end
      en = 1'b1; ack = 1'b1;
      step();
      chk_all("back_to_back", 1'b1, 2'd3);

      // Release with nothing pending returns to idle on the ack edge.
      req = '0;
      step();
      chk_all("release_idle", 1'b0, 2'd0);

      ack = 1'b0; en = 1'b0; req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_all($sformatf("en_low%0d", i), 1'b0, 2'd0);
      end

      // ack in IDLE is ignored; a later request is granted one cycle after it appears.
      en = 1'b1; req = '0; ack = 1'b1;
      step();
      chk_all("ack_idle", 1'b0, 2'd0);
      ack = 1'b0; req = 4'b0010;
      step();
      chk_all("late_req", 1'b1, 2'd1);

      // Asynchronous reset mid-cycle clears the held grant before the next edge.
      #3;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 1'b0, 2'd0);
      req = 4'b1111;
      step();
      chk_all("rst_held", 1'b0, 2'd0);
      rst = 1'b0;

      // Sequence of grants with every requester pending and ack held high.
      step();
      chk_all("seq0", 1'b1, seq_exp[0]);
      ack = 1'b1;
      for (int i = 1; i < 5; i++) begin
         step();
         chk_all($sformatf("seq%0d", i), 1'b1, seq_exp[i]);
      end
      en = 1'b0;
      step();
      chk_all("seq_end", 1'b0, 2'd0);
      ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
